// File: rtl/key_event_decoder_pkg.sv
// Shared constants for the key gesture decoder: state encoding and 50 MHz timing defaults.
package key_evt_pkg;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] PRESS1  = 3'd1;
  localparam logic [2:0] WAIT2   = 3'd2;
  localparam logic [2:0] LONG    = 3'd3;
  localparam logic [2:0] RELEASE = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE    = IDLE,
    ST_PRESS1  = PRESS1,
    ST_WAIT2   = WAIT2,
    ST_LONG    = LONG,
    ST_RELEASE = RELEASE
  } state_e;

  localparam int T_LONG   = 50_000_000;
  localparam int T_DBL    = 12_500_000;
  localparam int T_REPEAT = 10_000_000;
  localparam int CNT_W    = 26;

endpackage

// File: rtl/key_event_decoder.sv
// Classifies a debounced active-low key into short, double and long presses,
// with auto-repeat while a long press is held. All event outputs are one-cycle pulses.
module key_event_decoder #(
  parameter int CNT_W    = key_evt_pkg::CNT_W,
  parameter int LONG_T   = key_evt_pkg::T_LONG,
  parameter int DBL_T    = key_evt_pkg::T_DBL,
  parameter int REPEAT_T = key_evt_pkg::T_REPEAT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic pressed,
  output logic short_pulse,
  output logic double_pulse,
  output logic long_pulse,
  output logic repeat_pulse
);
  import key_evt_pkg::*;

  localparam logic [CNT_W-1:0] C_LONG_MAX = CNT_W'(LONG_T - 1);
  localparam logic [CNT_W-1:0] C_DBL_MAX  = CNT_W'(DBL_T - 1);
  localparam logic [CNT_W-1:0] C_REP_MAX  = (REPEAT_T == 0) ? '0 : CNT_W'(REPEAT_T - 1);

  state_e           r_state, w_state_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic             r_pressed, r_short, r_double, r_long, r_repeat;
  logic             w_short, w_double, w_long, w_repeat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_pressed <= 1'b0;
      r_short   <= 1'b0;
      r_double  <= 1'b0;
      r_long    <= 1'b0;
      r_repeat  <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_pressed <= ~key_n;
      r_short   <= w_short;
      r_double  <= w_double;
      r_long    <= w_long;
      r_repeat  <= w_repeat;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_short      = 1'b0;
    w_double     = 1'b0;
    w_long       = 1'b0;
    w_repeat     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cnt_next = '0;
        if (!key_n) w_state_next = ST_PRESS1;
      end
      ST_PRESS1: begin
        if (key_n) begin
          w_state_next = ST_WAIT2;
          w_cnt_next   = '0;
        end else if (r_cnt == C_LONG_MAX) begin
          w_state_next = ST_LONG;
          w_cnt_next   = '0;
          w_long       = 1'b1;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      ST_WAIT2: begin
        // A press on the last window cycle still wins over the short timeout.
        if (!key_n) begin
          w_state_next = ST_RELEASE;
          w_cnt_next   = '0;
          w_double     = 1'b1;
        end else if (r_cnt == C_DBL_MAX) begin
          w_state_next = ST_IDLE;
          w_cnt_next   = '0;
          w_short      = 1'b1;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      ST_LONG: begin
        if (key_n) begin
          w_state_next = ST_IDLE;
          w_cnt_next   = '0;
        end else if (REPEAT_T == 0) begin
          w_cnt_next = '0;
        end else if (r_cnt == C_REP_MAX) begin
          w_cnt_next = '0;
          w_repeat   = 1'b1;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      ST_RELEASE: begin
        w_cnt_next = '0;
        if (key_n) w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  assign pressed      = r_pressed;
  assign short_pulse  = r_short;
  assign double_pulse = r_double;
  assign long_pulse   = r_long;
  assign repeat_pulse = r_repeat;

endmodule
